multiport_accounter: RTL

MULTIPORT_ACCOUNTER -- requirements
Module: multiport_accounter

---
 rtl/accounter_pkg.sv | 16 +
 rtl/accounter_wrarb.sv | 45 ++++
 rtl/multiport_accounter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/accounter_pkg.sv
// Shared types for the multiport write accounter.
package accounter_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SEL_MAX = 8;

    typedef struct packed {
        logic               written;
        logic [SEL_MAX-1:0] select;
    } row_t;

endpackage

// File: rtl/accounter_wrarb.sv
// Per-cycle winner resolution among write agents that target the same row.
// Collision output exists only with MULTIPORT_ACCOUNTER_COLLISION_EN.
module accounter_wrarb #(
    parameter int ADDR_WIDTH   = 8,
    parameter int NB_WRAGENT   = 2,
    parameter int WR_PRIO_HIGH = 1
) (
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
`ifdef MULTIPORT_ACCOUNTER_COLLISION_EN
    output logic                             collide,
`endif
    output logic [NB_WRAGENT-1:0]            win
);

    // An agent loses if any higher-priority agent hits the same row.
    always_comb begin
        win = wren;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            for (int j = 0; j < NB_WRAGENT; j++) begin
                if (j != i && wren[i] && wren[j] &&
                    wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                    wraddr[j*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    if ((WR_PRIO_HIGH != 0) ? (j > i) : (j < i))
                        win[i] = 1'b0;
                end
            end
        end
    end

`ifdef MULTIPORT_ACCOUNTER_COLLISION_EN
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            for (int j = i + 1; j < NB_WRAGENT; j++) begin
                if (wren[i] && wren[j] &&
                    wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                    wraddr[j*ADDR_WIDTH +: ADDR_WIDTH])
                    collide = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/multiport_accounter.sv
// Tracks last writer per row with multiple read ports and an init sweep.
// Optional collision detect/counter: MULTIPORT_ACCOUNTER_COLLISION_EN.
module multiport_accounter
    import accounter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 2**ADDR_WIDTH,
    parameter int NB_WRAGENT   = 2,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = (NB_WRAGENT > 1) ? $clog2(NB_WRAGENT) : 1,
    parameter int WR_PRIO_HIGH = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               flush,
    output logic                               ready,
    input  logic [NB_WRAGENT-1:0]              wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr,
    input  logic [NB_RDAGENT-1:0]              rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr,
    output logic [NB_RDAGENT-1:0]              rdvalid,
    output logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect,
    output logic [NB_RDAGENT-1:0]              rdwritten,
    output logic                               wrcollision,
    output logic [CNT_WIDTH-1:0]               collision_cnt
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state;
    state_t                  state_n;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   ptr_n;
    logic [NB_WRAGENT-1:0]   win;
    logic                    run;
    row_t                    mem [RAM_DEPTH];
    row_t                    rd_n [NB_RDAGENT];

    assign run   = (state == RUN);
    assign ready = run;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        unique case (state)
            INIT: begin
                if (flush) begin
                    ptr_n = '0;
                end else if (ptr == LAST) begin
                    state_n = RUN;
                    ptr_n   = '0;
                end else begin
                    ptr_n = ptr + 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_n = INIT;
                    ptr_n   = '0;
                end
            end
            default: begin
                state_n = INIT;
                ptr_n   = '0;
            end
        endcase
    end

`ifdef MULTIPORT_ACCOUNTER_COLLISION_EN
    logic collide;

    accounter_wrarb #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NB_WRAGENT  (NB_WRAGENT),
        .WR_PRIO_HIGH(WR_PRIO_HIGH)
    ) u_wrarb (
        .wren   (wren),
        .wraddr (wraddr),
        .collide(collide),
        .win    (win)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wrcollision   <= 1'b0;
            collision_cnt <= '0;
        end else begin
            wrcollision <= run && collide;
            if (flush)
                collision_cnt <= '0;
            else if (run && collide && collision_cnt != '1)
                collision_cnt <= collision_cnt + 1'b1;
        end
    end
`else
    accounter_wrarb #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NB_WRAGENT  (NB_WRAGENT),
        .WR_PRIO_HIGH(WR_PRIO_HIGH)
    ) u_wrarb (
        .wren  (wren),
        .wraddr(wraddr),
        .win   (win)
    );

    assign wrcollision   = 1'b0;
    assign collision_cnt = '0;
`endif

    // Table needs no reset: the INIT sweep clears it and reads are masked.
    always_ff @(posedge aclk) begin
        if (!run) begin
            mem[ptr] <= '0;
        end else begin
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (win[i] &&
                    int'(wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]) < RAM_DEPTH)
                    mem[wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <=
                        '{written: 1'b1, select: SEL_MAX'(i)};
            end
        end
    end

    // Write-first: a same-cycle winning write overrides the stored row.
    always_comb begin
        for (int r = 0; r < NB_RDAGENT; r++) begin
            rd_n[r] = '0;
            if (int'(rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]) < RAM_DEPTH)
                rd_n[r] = mem[rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (win[i] &&
                    wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                    rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH])
                    rd_n[r] = '{written: 1'b1, select: SEL_MAX'(i)};
            end
            if (!run)
                rd_n[r] = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdvalid   <= '0;
            rdselect  <= '0;
            rdwritten <= '0;
        end else begin
            rdvalid <= rden;
            for (int r = 0; r < NB_RDAGENT; r++) begin
                if (rden[r]) begin
                    rdwritten[r] <= rd_n[r].written;
                    rdselect[r*SELECT_WIDTH +: SELECT_WIDTH] <=
                        rd_n[r].select[SELECT_WIDTH-1:0];
                end
            end
        end
    end

endmodule
